mem_arbiter: RTL and testbench

- Shares the single main-memory port (fixed-latency, unreset, byte/word-store memory) between the instruction-cache requester (port 0) and the data-cache requester (port 1).
- Runs one transaction at a time. Reads are issued as one-cycle pulses so exactly one valid token enters the memory's delay pipeline. The matching response is then routed back to the requester that issued it.
- Adds round-robin fairness, a post-reset drain and a response timeout.

---
 rtl/mem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one fixed-latency main-memory port between the instruction cache
// (port 0) and the data cache (port 1). Only one transaction is in progress
// at a time.
//
// Transaction flow:
//   IDLE  -> ISSUE : a request is sampled and latched
//   ISSUE -> IDLE  : store, completes in the ISSUE cycle
//   ISSUE -> WAIT  : line read
//   WAIT  -> IDLE  : response or timeout
//
// Reads are issued as a single-cycle mem_req_o pulse. This puts exactly one
// valid token into the memory's delay pipeline. When the response comes
// back, it is routed to the port that was granted.
//
// Arbitration is round-robin when both ports request together.
//
// After reset the FSM spends DATA_TRANSFER_TIME cycles in DRAIN. The memory
// pipeline is not reset, so a read token that was in flight when reset hit
// can still pop out. Any such token arrives during DRAIN and is discarded.
//
// A read that gets no response within TIMEOUT_CYCLES WAIT cycles completes
// with zero data and sets the sticky err_o flag.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_i[p]               request from port p, held until done_o[p]
//   store_i[p]             1 = store, 0 = line read
//   store_word_i[p]        1 = word store, 0 = byte store (data in [7:0])
//   addr_i[p], wdata_i[p]  request address / store data
//   done_o[p]              one-cycle completion pulse for port p
//   rdata_o                read line, valid with a read done_o, else 0
//   err_o                  sticky read-timeout flag
//   mem_*_o                request side of the memory port
//   mem_fill_data_i        memory read line
//   mem_response_valid_i   memory read response strobe
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDRESS_WIDTH      = 32,
   parameter int FILL_DATA_WIDTH    = 128,
   parameter int STORE_DATA_WIDTH   = 32,
   parameter int DATA_TRANSFER_TIME = 5,
   parameter int TIMEOUT_CYCLES     = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [1:0]                  req_i,
   input  logic [1:0]                  store_i,
   input  logic [1:0]                  store_word_i,
   input  logic [ADDRESS_WIDTH-1:0]    addr_i [2],
   input  logic [STORE_DATA_WIDTH-1:0] wdata_i [2],
   output logic [1:0]                  done_o,
   output logic [FILL_DATA_WIDTH-1:0]  rdata_o,
   output logic                        err_o,
   output logic                        mem_req_o,
   output logic                        mem_store_o,
   output logic                        mem_store_word_o,
   output logic [ADDRESS_WIDTH-1:0]    mem_addr_o,
   output logic [STORE_DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [FILL_DATA_WIDTH-1:0]  mem_fill_data_i,
   input  logic                        mem_response_valid_i
);

   localparam int DW = $clog2(DATA_TRANSFER_TIME + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_DRAIN,
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   state_t                      state_reg;
   logic [DW-1:0]               drain_cnt_reg;
   logic [TW-1:0]               timeout_cnt_reg;
   logic                        last_grant_reg;
   logic                        grant_reg;
   logic                        store_reg;
   logic                        store_word_reg;
   logic [ADDRESS_WIDTH-1:0]    addr_reg;
   logic [STORE_DATA_WIDTH-1:0] wdata_reg;
   logic                        mem_req_reg;
   logic                        store_done_reg;
   logic                        err_reg;

   logic                        win_next;
   logic                        resp_hit;
   logic                        timeout_hit;
   logic                        read_done;
   logic                        any_done;

   // Arbitration on the requests sampled this cycle.
   // When both ports request, the port that was not served last time wins.
   always_comb begin
      win_next = 1'b0;
      unique case (req_i)
         2'b01:   win_next = 1'b0;
         2'b10:   win_next = 1'b1;
         2'b11:   win_next = ~last_grant_reg;
         default: win_next = 1'b0;
      endcase
   end

   // Memory responses only count while a read is outstanding.
   assign resp_hit = (state_reg == S_WAIT) && mem_response_valid_i;

   // timeout_cnt_reg holds the number of WAIT cycles already completed.
   // The timeout therefore fires in the TIMEOUT_CYCLES-th WAIT cycle if no
   // response has been seen. A response arriving in that same cycle takes
   // priority over the timeout.
   assign timeout_hit = (state_reg == S_WAIT) && !mem_response_valid_i &&
                        (timeout_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

   assign read_done = resp_hit || timeout_hit;
   assign any_done  = store_done_reg || read_done;

   // Response data passes straight through in the response cycle.
   // It is zero in every other cycle, including a timed-out read.
   assign rdata_o = resp_hit ? mem_fill_data_i : '0;

   // Completion is steered to the latched grant, so at most one bit is high.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_done
         assign done_o[gi] = any_done && (grant_reg == 1'(gi));
      end
   endgenerate

   // The memory control signals come from the latched request.
   // The memory only acts on them while mem_req_o is high (the ISSUE cycle).
   assign mem_req_o        = mem_req_reg;
   assign mem_store_o      = store_reg;
   assign mem_store_word_o = store_word_reg;
   assign mem_addr_o       = addr_reg;
   assign mem_wdata_o      = wdata_reg;
   assign err_o            = err_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= S_DRAIN;
         drain_cnt_reg   <= DW'(DATA_TRANSFER_TIME);
         timeout_cnt_reg <= '0;
         last_grant_reg  <= 1'b0;
         grant_reg       <= 1'b0;
         store_reg       <= 1'b0;
         store_word_reg  <= 1'b0;
         addr_reg        <= '0;
         wdata_reg       <= '0;
         mem_req_reg     <= 1'b0;
         store_done_reg  <= 1'b0;
         err_reg         <= 1'b0;
      end else begin
         // Request and store completion are single-cycle pulses.
         // Both are owned by the ISSUE cycle.
         mem_req_reg    <= 1'b0;
         store_done_reg <= 1'b0;

         unique case (state_reg)
            S_DRAIN: begin
               // Stay here long enough for any pre-reset read token to leave
               // the memory pipeline. Its response is ignored.
               drain_cnt_reg <= drain_cnt_reg - 1'b1;
               if (drain_cnt_reg <= DW'(1)) begin
                  state_reg <= S_IDLE;
               end
            end

            S_IDLE: begin
               if (|req_i) begin
                  grant_reg      <= win_next;
                  last_grant_reg <= win_next;
                  store_reg      <= store_i[win_next];
                  store_word_reg <= store_word_i[win_next];
                  addr_reg       <= addr_i[win_next];
                  wdata_reg      <= wdata_i[win_next];
                  mem_req_reg    <= 1'b1;
                  // A store commits at the end of ISSUE, so its done pulse
                  // is raised in the ISSUE cycle itself.
                  store_done_reg <= store_i[win_next];
                  state_reg      <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               if (store_reg) begin
                  state_reg <= S_IDLE;
               end else begin
                  timeout_cnt_reg <= '0;
                  state_reg       <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (mem_response_valid_i) begin
                  state_reg <= S_IDLE;
               end else if (timeout_hit) begin
                  err_reg   <= 1'b1;
                  state_reg <= S_IDLE;
               end else begin
                  timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
               end
            end

            default: state_reg <= S_DRAIN;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter.
//
// Memory model:
//   - 256-byte store with fixed read latency.
//   - Word stores and byte stores.
//   - The read pipeline is not reset, matching the real memory.
//   - A mute control suppresses responses so the timeout path can be tested.
//
// Expected read lines are computed from the initial-content formula plus the
// hand-applied effect of the stores made by the bench.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int AW  = 32;
   localparam int FW  = 128;
   localparam int SW  = 32;
   localparam int DTT = 5;
   localparam int TOC = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic [1:0]    req_i;
   logic [1:0]    store_i;
   logic [1:0]    store_word_i;
   logic [AW-1:0] addr_i [2];
   logic [SW-1:0] wdata_i [2];
   logic [1:0]    done_o;
   logic [FW-1:0] rdata_o;
   logic          err_o;
   logic          mem_req_o;
   logic          mem_store_o;
   logic          mem_store_word_o;
   logic [AW-1:0] mem_addr_o;
   logic [SW-1:0] mem_wdata_o;
   logic [FW-1:0] mem_fill;
   logic          mem_resp;

   mem_arbiter #(
      .ADDRESS_WIDTH      (AW),
      .FILL_DATA_WIDTH    (FW),
      .STORE_DATA_WIDTH   (SW),
      .DATA_TRANSFER_TIME (DTT),
      .TIMEOUT_CYCLES     (TOC)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .req_i                (req_i),
      .store_i              (store_i),
      .store_word_i         (store_word_i),
      .addr_i               (addr_i),
      .wdata_i              (wdata_i),
      .done_o               (done_o),
      .rdata_o              (rdata_o),
      .err_o                (err_o),
      .mem_req_o            (mem_req_o),
      .mem_store_o          (mem_store_o),
      .mem_store_word_o     (mem_store_word_o),
      .mem_addr_o           (mem_addr_o),
      .mem_wdata_o          (mem_wdata_o),
      .mem_fill_data_i      (mem_fill),
      .mem_response_valid_i (mem_resp)
   );

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] init_byte(input int a);
      return 8'((a * 7 + 3) & 255);
   endfunction

   function automatic logic [127:0] init_line(input int a);
      logic [127:0] l;
      int b;
      b = a & 32'hF0;
      l = '0;
      for (int i = 0; i < 16; i++) l[8*i +: 8] = init_byte(b + i);
      return l;
   endfunction

   // ---------------- memory model ----------------
   logic          mem_init;
   logic          mute;
   logic [7:0]    mem_b [256];
   logic          vpipe [DTT];
   logic [AW-1:0] apipe [DTT];
   logic [7:0]    fill_base;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem_b[i] <= init_byte(i);
         for (int i = 0; i < DTT; i++) begin
            vpipe[i] <= 1'b0;
            apipe[i] <= '0;
         end
      end else begin
         if (mem_req_o && mem_store_o) begin
            if (mem_store_word_o) begin
               for (int i = 0; i < 4; i++)
                  mem_b[(mem_addr_o[7:0] & 8'hFC) + 8'(i)] <= mem_wdata_o[8*i +: 8];
            end else begin
               mem_b[mem_addr_o[7:0]] <= mem_wdata_o[7:0];
            end
         end
         vpipe[0] <= mem_req_o && !mem_store_o;
         apipe[0] <= mem_addr_o;
         for (int i = 1; i < DTT; i++) begin
            vpipe[i] <= vpipe[i-1];
            apipe[i] <= apipe[i-1];
         end
      end
   end

   assign fill_base = apipe[DTT-1][7:0] & 8'hF0;

   always_comb begin
      mem_fill = '0;
      for (int i = 0; i < 16; i++) mem_fill[8*i +: 8] = mem_b[fill_base + 8'(i)];
   end

   assign mem_resp = vpipe[DTT-1] && !mute;

   // ---------------- monitor ----------------
   int mreq_cnt   = 0;
   int done0_cnt  = 0;
   int done1_cnt  = 0;
   int onehot_bad = 0;
   int rdata_bad  = 0;

   always @(negedge clk) begin
      if (mem_req_o)                     mreq_cnt   <= mreq_cnt + 1;
      if (done_o[0])                     done0_cnt  <= done0_cnt + 1;
      if (done_o[1])                     done1_cnt  <= done1_cnt + 1;
      if (done_o == 2'b11)               onehot_bad <= onehot_bad + 1;
      if (done_o == 2'b00 && rdata_o != '0) rdata_bad <= rdata_bad + 1;
   end

   // ---------------- helpers ----------------
   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      req_i = 2'b00;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Called just after a clock edge. Cycle numbers count negedges from the
   // call, so the first cycle is 1.
   task automatic run_txn(input int port, input logic st, input logic sw,
                          input logic [AW-1:0] addr, input logic [SW-1:0] wd,
                          output int issue_at, output int done_at,
                          output logic [127:0] data, output logic sw_seen,
                          output logic [SW-1:0] wd_seen);
      int cyc;
      store_i[port]      = st;
      store_word_i[port] = sw;
      addr_i[port]       = addr;
      wdata_i[port]      = wd;
      req_i[port]        = 1'b1;
      issue_at = 0;
      done_at  = 0;
      data     = '0;
      sw_seen  = 1'b0;
      wd_seen  = '0;
      cyc      = 0;
      while (done_at == 0 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (mem_req_o && issue_at == 0) begin
            issue_at = cyc;
            sw_seen  = mem_store_word_o;
            wd_seen  = mem_wdata_o;
         end
         if (done_o[port]) begin
            done_at = cyc;
            data    = rdata_o;
         end
      end
      @(posedge clk); #1;
      req_i[port] = 1'b0;
      $display("txn port=%0d store=%0b addr=%0h issue=%0d done=%0d data=%0h",
               port, st, addr, issue_at, done_at, data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int issue_at, done_at, snap, d0, n, cyc;
      logic [127:0] data, exp;
      logic sw_seen;
      logic [SW-1:0] wd_seen;
      logic [1:0] order [4];
      logic [127:0] odata [4];

      reset        = 1'b1;
      mem_init     = 1'b1;
      mute         = 1'b0;
      req_i        = 2'b00;
      store_i      = 2'b00;
      store_word_i = 2'b00;
      for (int i = 0; i < 2; i++) begin
         addr_i[i]  = '0;
         wdata_i[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1 mem_init = 1'b0;

      // Reset state.
      do_reset();
      @(negedge clk);
      check_val("rst_done",   128'(done_o),    128'(0));
      check_val("rst_memreq", 128'(mem_req_o), 128'(0));
      check_val("rst_err",    128'(err_o),     128'(0));
      check_val("rst_addr",   128'(mem_addr_o), 128'(0));
      check_val("rst_rdata",  rdata_o,         128'(0));

      // Test 1: read held from the first post-reset cycle.
      do_reset();
      snap = mreq_cnt;
      run_txn(0, 1'b0, 1'b0, 32'h40, 32'h0, issue_at, done_at, data, sw_seen, wd_seen);
      check_val("t1_issue_cycle", 128'(issue_at), 128'(DTT + 2));
      check_val("t1_latency", 128'(done_at - issue_at), 128'(DTT));
      check_val("t1_data", data, init_line(32'h40));
      check_val("t1_one_req", 128'(mreq_cnt - snap), 128'(1));

      // Test 2: word store, then read it back.
      run_txn(1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, issue_at, done_at, data, sw_seen, wd_seen);
      check_val("t2_st_done", 128'(done_at), 128'(2));
      check_val("t2_st_word", 128'(sw_seen), 128'(1));
      run_txn(1, 1'b0, 1'b0, 32'h10, 32'h0, issue_at, done_at, data, sw_seen, wd_seen);
      exp = init_line(32'h10);
      exp[31:0] = 32'hDEADBEEF;
      check_val("t2_rd_done", 128'(done_at), 128'(DTT + 2));
      check_val("t2_rd_data", data, exp);

      // Test 4: byte store into the top byte of that word.
      run_txn(0, 1'b1, 1'b0, 32'h13, 32'hFFFFFF5A, issue_at, done_at, data, sw_seen, wd_seen);
      check_val("t4_st_word", 128'(sw_seen), 128'(0));
      check_val("t4_wdata", 128'(wd_seen[7:0]), 128'(8'h5A));
      check_val("t4_st_done", 128'(done_at), 128'(2));
      run_txn(0, 1'b0, 1'b0, 32'h10, 32'h0, issue_at, done_at, data, sw_seen, wd_seen);
      exp[31:0] = 32'h5AADBEEF;
      check_val("t4_rd_data", data, exp);

      // Test 3: both ports read continuously; grants start with port 1.
      do_reset();
      store_i   = 2'b00;
      addr_i[0] = 32'h30;
      addr_i[1] = 32'h20;
      req_i     = 2'b11;
      n   = 0;
      cyc = 0;
      while (n < 4 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (done_o != 2'b00) begin
            order[n] = done_o;
            odata[n] = rdata_o;
            n++;
         end
      end
      @(posedge clk); #1;
      req_i = 2'b00;
      check_val("t3_count", 128'(n), 128'(4));
      for (int k = 0; k < 4; k++) begin
         check_val($sformatf("t3_grant%0d", k), 128'(order[k]),
                   (k % 2 == 0) ? 128'(2'b10) : 128'(2'b01));
         check_val($sformatf("t3_data%0d", k), odata[k],
                   (k % 2 == 0) ? init_line(32'h20) : init_line(32'h30));
      end

      // Test 5: no response, so the read times out; the next read still works.
      check_val("t5_err_before", 128'(err_o), 128'(0));
      mute = 1'b1;
      run_txn(0, 1'b0, 1'b0, 32'h60, 32'h0, issue_at, done_at, data, sw_seen, wd_seen);
      check_val("t5_to_latency", 128'(done_at - issue_at), 128'(TOC));
      check_val("t5_to_data", data, 128'(0));
      check_val("t5_err_set", 128'(err_o), 128'(1));
      mute = 1'b0;
      run_txn(1, 1'b0, 1'b0, 32'h70, 32'h0, issue_at, done_at, data, sw_seen, wd_seen);
      check_val("t5_next_done", 128'(done_at), 128'(DTT + 2));
      check_val("t5_next_data", data, init_line(32'h70));
      check_val("t5_err_sticky", 128'(err_o), 128'(1));

      // Test 6: reset while a read is in WAIT; the stale response lands in DRAIN.
      do_reset();
      @(negedge clk);
      check_val("t6_err_cleared", 128'(err_o), 128'(0));
      store_i[0] = 1'b0;
      addr_i[0]  = 32'h40;
      req_i[0]   = 1'b1;
      cyc = 0;
      while (!mem_req_o && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check_val("t6_issue_seen", 128'(mem_req_o), 128'(1));
      d0 = done0_cnt;
      @(posedge clk); #1;
      reset = 1'b1;
      req_i = 2'b00;
      @(posedge clk); #1;
      reset = 1'b0;
      run_txn(1, 1'b0, 1'b0, 32'h50, 32'h0, issue_at, done_at, data, sw_seen, wd_seen);
      check_val("t6_done_cycle", 128'(done_at), 128'(DTT + 7));
      check_val("t6_data", data, init_line(32'h50));
      check_val("t6_no_stale_done", 128'(done0_cnt - d0), 128'(0));

      // Invariants gathered by the monitor.
      repeat (2) @(posedge clk);
      check_val("onehot_done", 128'(onehot_bad), 128'(0));
      check_val("rdata_idle_zero", 128'(rdata_bad), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
